// File: rtl/shift_sweep_seq_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift sweep sequencer: default operand/amount
// widths and the controller state encoding.
// ---------------------------------------------------------------------------
package shift_pkg;

  // Default operand/result width and the matching shift-amount width
  localparam int DATA_W_DEF = 8;
  localparam int AMT_W_DEF  = $clog2(DATA_W_DEF);

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/shift_sweep_seq_if.sv
// ---------------------------------------------------------------------------
// shift_sweep_seq_if
// Bundles the request, shifter and result signals of the sweep sequencer.
//   start/op_in/amt_lo/amt_hi/clr : sweep request and abort
//   sh_a/sh_amt/sh_y              : downstream shifter operand, amount, result
//   res_data/res_amt/res_valid/res_ready : result stream with handshake
//   busy/done/err                 : status
// The slave modport is the sequencer; master is whoever drives it.
// ---------------------------------------------------------------------------
interface shift_sweep_seq_if
  import shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AMT_W  = AMT_W_DEF
);

  logic              start;
  logic [DATA_W-1:0] op_in;
  logic [AMT_W-1:0]  amt_lo;
  logic [AMT_W-1:0]  amt_hi;
  logic              clr;
  logic [DATA_W-1:0] sh_a;
  logic [AMT_W-1:0]  sh_amt;
  logic [DATA_W-1:0] sh_y;
  logic [DATA_W-1:0] res_data;
  logic [AMT_W-1:0]  res_amt;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, op_in, amt_lo, amt_hi, clr, sh_y, res_ready,
    output sh_a, sh_amt, res_data, res_amt, res_valid, busy, done, err
  );

  modport master (
    output start, op_in, amt_lo, amt_hi, clr, sh_y, res_ready,
    input  sh_a, sh_amt, res_data, res_amt, res_valid, busy, done, err
  );

endinterface

// File: rtl/shift_sweep_seq.sv
// ---------------------------------------------------------------------------
// shift_sweep_seq
// Sweeps an external combinational shifter over the amounts amt_lo..amt_hi
// for a single latched operand, emitting one (amount, result) pair per step
// through a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : shift_sweep_seq_if slave modport (request, shifter, result, status)
// ---------------------------------------------------------------------------
module shift_sweep_seq
  import shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int AMT_W  = AMT_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  shift_sweep_seq_if.slave bus
);

  state_e            state_q,    state_d;
  logic [AMT_W-1:0]  curAmt_q,   curAmt_d;
  logic [AMT_W-1:0]  amtHi_q,    amtHi_d;
  logic [DATA_W-1:0] shA_q,      shA_d;
  logic [AMT_W-1:0]  shAmt_q,    shAmt_d;
  logic [DATA_W-1:0] resData_q,  resData_d;
  logic [AMT_W-1:0]  resAmt_q,   resAmt_d;
  logic              resValid_q, resValid_d;
  logic              done_q,     done_d;
  logic              err_q,      err_d;

  // Next-state logic. clr wins over everything, including a start or a
  // handshake in the same cycle. done/err are registered so they are high
  // exactly while the controller sits in FIN.
  always_comb begin
    state_d    = state_q;
    curAmt_d   = curAmt_q;
    amtHi_d    = amtHi_q;
    shA_d      = shA_q;
    shAmt_d    = shAmt_q;
    resData_d  = resData_q;
    resAmt_d   = resAmt_q;
    resValid_d = resValid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (bus.clr) begin
      state_d    = IDLE;
      resValid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.amt_lo <= bus.amt_hi) begin
              curAmt_d = bus.amt_lo;
              amtHi_d  = bus.amt_hi;
              shA_d    = bus.op_in;
              shAmt_d  = bus.amt_lo;
              state_d  = DRIVE;
            end else begin
              state_d = FIN;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end
          end
        end
        DRIVE: begin
          resData_d  = bus.sh_y;
          resAmt_d   = curAmt_q;
          resValid_d = 1'b1;
          state_d    = WAIT;
        end
        WAIT: begin
          // Compare before incrementing so a top-of-range amt_hi never wraps
          if (resValid_q && bus.res_ready) begin
            resValid_d = 1'b0;
            if (curAmt_q == amtHi_q) begin
              state_d = FIN;
              done_d  = 1'b1;
            end else begin
              curAmt_d = curAmt_q + 1'b1;
              shAmt_d  = curAmt_q + 1'b1;
              state_d  = DRIVE;
            end
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers; reset clears every output immediately, even mid-sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      curAmt_q   <= '0;
      amtHi_q    <= '0;
      shA_q      <= '0;
      shAmt_q    <= '0;
      resData_q  <= '0;
      resAmt_q   <= '0;
      resValid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      curAmt_q   <= curAmt_d;
      amtHi_q    <= amtHi_d;
      shA_q      <= shA_d;
      shAmt_q    <= shAmt_d;
      resData_q  <= resData_d;
      resAmt_q   <= resAmt_d;
      resValid_q <= resValid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.sh_a      = shA_q;
  assign bus.sh_amt    = shAmt_q;
  assign bus.res_data  = resData_q;
  assign bus.res_amt   = resAmt_q;
  assign bus.res_valid = resValid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
